// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UartTx among NUM_REQ
// byte sources. One byte per grant; write strobe held until busy is seen.
//
// Optional feature macro: UART_TX_ARB_HOLD_EN
//   When defined, adds hold_i so the most recent owner can keep the
//   transmitter for consecutive bytes of a multi-byte message.
//
// Ports:
//   clock_i     system clock, rising edge
//   reset_i     asynchronous active-low reset
//   req_i       per-requester byte pending (held until its grant)
//   req_data_i  byte of requester k at [8k+7:8k]
//   hold_i      (UART_TX_ARB_HOLD_EN only) keep ownership while requesting
//   grant_o     one-cycle one-hot acknowledge, byte captured
//   owner_o     index of current / most recent grantee
//   active_o    high from grant until the transmitter finishes the byte
//   tx_write_o  to UartTx write_i
//   tx_data_o   to UartTx data_i, registered
//   tx_busy_i   from UartTx busy_o

module uart_tx_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int OWNER_W = 2
) (
   input  logic                 clock_i,
   input  logic                 reset_i,
   input  logic [NUM_REQ-1:0]   req_i,
   input  logic [8*NUM_REQ-1:0] req_data_i,
`ifdef UART_TX_ARB_HOLD_EN
   input  logic [NUM_REQ-1:0]   hold_i,
`endif
   output logic [NUM_REQ-1:0]   grant_o,
   output logic [OWNER_W-1:0]   owner_o,
   output logic                 active_o,
   output logic                 tx_write_o,
   output logic [7:0]           tx_data_o,
   input  logic                 tx_busy_i
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t               state_q;
   state_t               state_d;
   logic [OWNER_W-1:0]   last_q;
   logic [OWNER_W-1:0]   last_d;
   logic [OWNER_W-1:0]   owner_q;
   logic [OWNER_W-1:0]   owner_d;
   logic [NUM_REQ-1:0]   grant_q;
   logic [NUM_REQ-1:0]   grant_d;
   logic                 write_q;
   logic                 write_d;
   logic [7:0]           data_q;
   logic [7:0]           data_d;

   logic                 found;
   logic [OWNER_W-1:0]   win;
   logic [7:0]           win_data;
   logic [NUM_REQ-1:0]   win_onehot;

   // Winner search: first set request upward from last_q+1, wrapping.
   // Offsets run 1..NUM_REQ so last_q itself is considered last.
   always_comb begin
      found = 1'b0;
      win   = last_q;
`ifdef UART_TX_ARB_HOLD_EN
      // A holding owner that still requests keeps the transmitter.
      if (hold_i[last_q] && req_i[last_q]) begin
         found = 1'b1;
         win   = last_q;
      end
`endif
      for (int off = 1; off <= NUM_REQ; off++) begin
         for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_i[k] &&
                k == ((int'(last_q) + off) % NUM_REQ)) begin
               found = 1'b1;
               win   = OWNER_W'(k);
            end
         end
      end
   end

   always_comb begin
      win_data   = 8'h00;
      win_onehot = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (win == OWNER_W'(k)) begin
            win_data      = req_data_i[k*8 +: 8];
            win_onehot[k] = 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      owner_d = owner_q;
      grant_d = '0;
      write_d = write_q;
      data_d  = data_q;
      unique case (state_q)
         IDLE: begin
            if (!tx_busy_i && found) begin
               state_d = ISSUE;
               last_d  = win;
               owner_d = win;
               grant_d = win_onehot;
               write_d = 1'b1;
               data_d  = win_data;
            end
         end
         ISSUE: begin
            if (tx_busy_i) begin
               state_d = DRAIN;
               write_d = 1'b0;
            end
         end
         DRAIN: begin
            if (!tx_busy_i) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            write_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= IDLE;
         last_q  <= OWNER_W'(NUM_REQ - 1);
         owner_q <= '0;
         grant_q <= '0;
         write_q <= 1'b0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         write_q <= write_d;
         data_q  <= data_d;
      end
   end

   assign grant_o    = grant_q;
   assign owner_o    = owner_q;
   assign active_o   = (state_q != IDLE);
   assign tx_write_o = write_q;
   assign tx_data_o  = data_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed self-checking bench for uart_tx_arbiter.
// Steps through reset, single byte, fairness, busy-at-idle, wrap, hold.

module tb_uart_tx_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  hold;
   logic [3:0]  grant;
   logic [1:0]  owner;
   logic        active;
   logic        tx_write;
   logic [7:0]  tx_data;
   logic        tx_busy;

   int passed = 0;
   int total  = 0;

   uart_tx_arbiter #(.NUM_REQ(4), .OWNER_W(2)) dut (
      .clock_i    (clk),
      .reset_i    (rst_n),
      .req_i      (req),
      .req_data_i (req_data),
`ifdef UART_TX_ARB_HOLD_EN
      .hold_i     (hold),
`endif
      .grant_o    (grant),
      .owner_o    (owner),
      .active_o   (active),
      .tx_write_o (tx_write),
      .tx_data_o  (tx_data),
      .tx_busy_i  (tx_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] byte_of(input int k);
      logic [31:0] d;
      d = req_data;
      return d[k*8 +: 8];
   endfunction

   // One full byte: grant edge, busy seen, busy falls back to IDLE.
   task automatic xfer(input int k, input string tag);
      logic [3:0] oh;
      oh = 4'b0001 << k;
      step();
      chk({tag, ".grant"}, {28'd0, grant}, {28'd0, oh});
      chk({tag, ".owner"}, {30'd0, owner}, k);
      chk({tag, ".data"}, {24'd0, tx_data}, {24'd0, byte_of(k)});
      chk({tag, ".write"}, {31'd0, tx_write}, 1);
      chk({tag, ".active"}, {31'd0, active}, 1);
      tx_busy = 1'b1;
      step();
      chk({tag, ".write_drop"}, {31'd0, tx_write}, 0);
      chk({tag, ".grant_drain"}, {28'd0, grant}, 0);
      chk({tag, ".active_drain"}, {31'd0, active}, 1);
      tx_busy = 1'b0;
      step();
      chk({tag, ".active_idle"}, {31'd0, active}, 0);
      chk({tag, ".grant_idle"}, {28'd0, grant}, 0);
   endtask

   initial begin
      rst_n    = 1'b0;
      req      = 4'b0000;
      req_data = {8'h43, 8'h55, 8'h21, 8'h10};
      hold     = 4'b0000;
      tx_busy  = 1'b0;
      step();
      step();
      chk("rst.grant", {28'd0, grant}, 0);
      chk("rst.owner", {30'd0, owner}, 0);
      chk("rst.active", {31'd0, active}, 0);
      chk("rst.write", {31'd0, tx_write}, 0);
      chk("rst.data", {24'd0, tx_data}, 0);
      rst_n = 1'b1;

      // Single byte from requester 2, busy rising 3 cycles after write.
      req = 4'b0100;
      step();
      chk("one.grant", {28'd0, grant}, 32'h4);
      chk("one.data", {24'd0, tx_data}, 32'h55);
      chk("one.write", {31'd0, tx_write}, 1);
      chk("one.owner", {30'd0, owner}, 2);
      req = 4'b0000;
      step();
      chk("one.grant1", {28'd0, grant}, 0);
      chk("one.write1", {31'd0, tx_write}, 1);
      step();
      chk("one.write2", {31'd0, tx_write}, 1);
      tx_busy = 1'b1;
      step();
      chk("one.write3", {31'd0, tx_write}, 0);
      chk("one.active3", {31'd0, active}, 1);
      step();
      chk("one.active4", {31'd0, active}, 1);
      tx_busy = 1'b0;
      step();
      chk("one.active5", {31'd0, active}, 0);
      chk("one.grant5", {28'd0, grant}, 0);

      // Requester 3 is next by rotation; reset asynchronously mid-DRAIN.
      req = 4'b1000;
      step();
      chk("pre.grant", {28'd0, grant}, 32'h8);
      chk("pre.data", {24'd0, tx_data}, 32'h43);
      req = 4'b0000;
      tx_busy = 1'b1;
      step();
      step();
      chk("pre.active", {31'd0, active}, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("arst.owner", {30'd0, owner}, 0);
      chk("arst.active", {31'd0, active}, 0);
      chk("arst.write", {31'd0, tx_write}, 0);
      chk("arst.data", {24'd0, tx_data}, 0);
      chk("arst.grant", {28'd0, grant}, 0);
      rst_n   = 1'b1;
      tx_busy = 1'b0;
      req     = 4'b1111;

      // Fairness: 0 first after reset, then strict rotation.
      for (int i = 0; i < 8; i++) begin
         xfer(i % 4, $sformatf("rr%0d", i));
      end

      // Busy at idle blocks grants.
      req     = 4'b0010;
      tx_busy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk($sformatf("busy%0d.grant", i), {28'd0, grant}, 0);
         chk($sformatf("busy%0d.active", i), {31'd0, active}, 0);
      end
      tx_busy = 1'b0;
      xfer(1, "busy_rel");

      // Sparse wrap.
      req = 4'b1000;
      xfer(3, "wrap_a");
      req = 4'b1001;
      xfer(0, "wrap_b");
      req = 4'b1000;
      xfer(3, "wrap_c");

`ifdef UART_TX_ARB_HOLD_EN
      req = 4'b0010;
      xfer(1, "hold_pre");
      req  = 4'b0011;
      hold = 4'b0010;
      for (int i = 0; i < 3; i++) begin
         xfer(1, $sformatf("hold%0d", i));
      end
      hold = 4'b0000;
      xfer(0, "hold_rel");
`endif

      req = 4'b0000;
      step();
      chk("end.grant", {28'd0, grant}, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin arbiter that shares a single UartTx transmitter among NUM_REQ byte sources. Sits between the requesting blocks and the UartTx write_i/data_i/busy_o interface. Grants one byte at a time, sequences the write strobe against the transmitter's busy flag, and returns a one-cycle acknowledge to the winning requester. Frame format (parity, stop bits, divider) is driven to UartTx separately and is not touched here.

## Interface
- NUM_REQ, 4, number of requesters; legal range 2..8.
- OWNER_W, 2, owner index width; must equal ceil(log2(NUM_REQ)).

- clock_i  in  1  system clock; all state on rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- req_i  in  NUM_REQ  per-requester byte pending; held until matching grant_o bit pulses.
- req_data_i  in  8*NUM_REQ  byte for requester k at bits [8k+7:8k]; stable while req_i[k] high.
- grant_o  out  NUM_REQ  one-cycle, one-hot acknowledge; byte captured.
- owner_o  out  OWNER_W  index of the current or most recent grantee.
- active_o  out  1  high from grant until the transmitter finishes the byte.
- tx_write_o  out  1  to UartTx write_i.
- tx_data_o  out  8  to UartTx data_i; registered, stable while tx_write_o high.
- tx_busy_i  in  1  from UartTx busy_o.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: when tx_busy_i==0 and any req_i bit is set, pick the winner, then on the next edge:
  - capture the winner's byte into tx_data_o;
  - set owner_o and tx_write_o=1, pulse grant_o[winner];
  - go to ISSUE.
- While tx_busy_i==1 in IDLE (e.g. transmitter still leaving reset), no grant is issued.
- Winner is the first set req_i bit searching upward from (last_owner+1) mod NUM_REQ, wrapping. last_owner resets to NUM_REQ-1, so requester 0 has first priority after reset.
- ISSUE: hold tx_write_o=1 until tx_busy_i sampled 1; on that edge drop tx_write_o and go to DRAIN.
- DRAIN: wait for tx_busy_i==0; on that edge go to IDLE.
- active_o=1 in ISSUE and DRAIN.
- Requests deasserted before a grant are dropped silently. req_i changes in ISSUE or DRAIN have no effect until IDLE.
- Reset (any time, including mid-byte): state IDLE, last_owner=NUM_REQ-1, all outputs 0. tx_write_o falls asynchronously with reset.

## Timing
- Reset values: grant_o=0, owner_o=0, active_o=0, tx_write_o=0, tx_data_o=0x00.
- Request to grant: req_i sampled high in IDLE at edge N → grant_o, tx_write_o, tx_data_o and active_o valid after edge N.
- tx_write_o drops one cycle after the first cycle with tx_busy_i=1.
- Back-to-back: tx_busy_i falls, DRAIN→IDLE at edge M, next grant at edge M+1. Minimum one IDLE cycle between bytes.
- grant_o is never asserted in ISSUE or DRAIN. At most one grant per transmitted byte.

## Configuration
- UART_TX_ARB_HOLD_EN defined:
  - adds port hold_i (in, NUM_REQ).
  - In IDLE, if hold_i[last_owner] and req_i[last_owner] are both 1, last_owner wins again regardless of rotation, so multi-byte messages are not interleaved.
  - If hold_i[last_owner]=1 but req_i[last_owner]=0, ownership is released and normal round-robin applies.
- UART_TX_ARB_HOLD_EN undefined: no hold_i port; pure round-robin.

## Test plan
- Reset: pull reset_i low mid-DRAIN → all outputs 0 immediately; after release with tx_busy_i=0 and req_i=4'b1111 → grant_o=4'b0001 first.
- Single byte: req_i[2]=1, byte 0x55, model busy rising 3 cycles after write → one grant_o=4'b0100 pulse, tx_data_o=0x55, tx_write_o high exactly until busy seen, active_o low one cycle after busy falls.
- Fairness: all four requesting continuously for 8 bytes → grant order 0,1,2,3,0,1,2,3 and tx_data_o matches each requester's byte.
- Busy at idle: tx_busy_i held 1 with req_i=4'b0010 → no grant until busy falls; grant on the next edge after busy is sampled 0.
- Sparse wrap: owner=3, req_i=4'b1001 → requester 0 granted next; then req_i=4'b1000 → requester 3.
- With UART_TX_ARB_HOLD_EN: requester 1 has hold_i[1]=1 and req_i=4'b0011 for 3 bytes → grants 1,1,1; then hold_i[1]=0 → requester 0 granted next.
